minicpu_mc_top: RTL
===================

// Module: minicpu_mc_top
// PURPOSE
//  Multi-cycle LoongArch-32 subset core; next generation of the single-cycle minicpu.
//  FSM sequences IF/ID/EX/MEM/WB over req/ack memory ports, so instruction and data
//  SRAMs may have variable latency. Sits as the core top; SoC wraps it with SRAM/bridge.
//  ISA: add.w sub.w addi.w lu12i.w ld.w st.w beq bne b.
// PARAMETERS
//  RESET_PC  32'h1c000000  first fetch address after reset
//  CNT_W     32            width of cycle/instret performance counters (8..64)
// PORTS
//  clk             in   1      single core clock, rising edge
//  resetn          in   1      asynchronous, active-low reset
//  inst_req        out  1      fetch request; held until inst_ack
//  inst_addr       out  32     fetch address (= pc); stable while inst_req
//  inst_ack        in   1      fetch done; inst_rdata valid this cycle
//  inst_rdata      in   32     fetched instruction
//  data_req        out  1      load/store request; held until data_ack
//  data_we         out  1      1 = store, 0 = load; stable while data_req
//  data_addr       out  32     rj + sext(si12); stable while data_req
//  data_wdata      out  32     store data (rd value)
//  data_ack        in   1      access done; data_rdata valid this cycle (loads)
//  data_rdata      in   32     load data
//  cycle_cnt       out  CNT_W  cycles since reset release
//  instret_cnt     out  CNT_W  instructions retired (WB state count)
// BEHAVIOUR
//  - States: IDLE -> IF -> ID -> EX -> {MEM if ld/st} -> WB -> IF. IDLE only after reset.
//  - Reset (resetn=0, any time, async): state=IDLE, pc=RESET_PC, all req/we=0,
//    addr/wdata=0, counters=0; an outstanding req is abandoned (no late ack honoured).
//  - IDLE: one cycle, then IF. IF: inst_req=1; on inst_ack latch ir, go ID.
//  - ack may arrive the same cycle req rises (zero-wait SRAM legal); ack outside req ignored.
//  - ID: regfile read rj, rk (rd for st.w/beq/bne); latch operands. EX: ALU/branch resolve.
//  - MEM: data_req=1, we per op; on data_ack latch rdata (ld), go WB.
//  - WB: rf write if gr_we and rd!=0 (r0 reads 0 always); pc<=next_pc; instret++.
//  - Min latency: 4 cycles ALU/branch, 5 cycles ld/st, plus memory wait cycles.
//  - Arithmetic mod 2^32; addi/ld/st imm = sext(inst[21:10]); lu12i.w = {inst[24:5],12'b0}.
//  - Branch: beq/bne target = pc + sext({inst[25:10],2'b0}); b target =
//    pc + sext({inst[9:0],inst[25:10],2'b0}); not taken -> pc+4. Wraps at 2^32.
//  - Undecoded instruction: executes as NOP (pc+4, no write), still counts instret.
//  - cycle_cnt increments every cycle state!=IDLE; both counters wrap to 0 at 2^CNT_W.
// CONFIGURATION
//  MINICPU_TRACE_EN defined: extra outputs debug_wb_pc[31:0], debug_wb_rf_we,
//    debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0], valid for one cycle in WB;
//    rf_we=0 for r0 targets and non-writing ops; all 0 outside WB and in reset.
//  Not defined: ports absent, no trace logic; core behaviour identical.
// STRUCTURE
//  minicpu_pkg: state_t enum (IDLE,IF,ID,EX,MEM,WB), alu_op_t enum, opcode field
//    constants for all nine instructions, RESET_PC default.
//  Sub-module minicpu_mc_decode: ir -> {alu_op, src2_is_imm, gr_we, mem_en, mem_we,
//    src_reg_is_rd, br_type, imm}; purely combinational. Existing regfile instanced as-is.
// TESTING
//  1 Reset: resetn=0 mid-MEM with data_req high -> data_req=0 same cycle; after release
//    first inst_addr=0x1c000000, counters=0.
//  2 addi.w r1,r0,5; addi.w r2,r0,-3; add.w r3,r1,r2; sub.w r4,r1,r2, zero-wait ->
//    r3=2, r4=8, instret=4 after 16 cycles of non-IDLE.
//  3 lu12i.w r5,0x12345; st.w r5,r0,0x10; ld.w r6,r0,0x10 with 3-cycle data_ack delay ->
//    data_addr=0x10, wdata=0x12345000, r6=0x12345000, data_req held 3 cycles each.
//  4 bne r1,r1,+8 not taken -> pc+4; beq r1,r1,-4 -> pc-4; b +0x100 -> pc+0x100.
//  5 addi.w r0,r0,7 then add.w r7,r0,r0 -> r7=0; 0xffffffff undecoded -> NOP, pc+4.
//  6 CNT_W=8: run 300 cycles -> cycle_cnt=300 mod 256=44; MINICPU_TRACE_EN on: each WB
//    pulses debug_wb_pc matching executed pc.

Source files
------------

// File: rtl/minicpu_pkg.sv
// Shared types and ISA constants for the multi-cycle minicpu core.
// Opcode constants are the fixed high-order instruction bits for each instruction format.
package minicpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IF   = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
  typedef logic [2:0] state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_LUI} alu_op_t;
  typedef enum logic [1:0] {BR_NONE, BR_BEQ, BR_BNE, BR_B} br_type_t;

  localparam logic [16:0] OP_ADD_W   = 17'h00020;  // inst[31:15]
  localparam logic [16:0] OP_SUB_W   = 17'h00022;
  localparam logic [9:0]  OP_ADDI_W  = 10'h00a;    // inst[31:22]
  localparam logic [9:0]  OP_LD_W    = 10'h0a2;
  localparam logic [9:0]  OP_ST_W    = 10'h0a6;
  localparam logic [6:0]  OP_LU12I_W = 7'h0a;      // inst[31:25]
  localparam logic [5:0]  OP_B       = 6'h14;      // inst[31:26]
  localparam logic [5:0]  OP_BEQ     = 6'h16;
  localparam logic [5:0]  OP_BNE     = 6'h17;

  typedef struct packed {
    alu_op_t     alu_op;
    logic        src2_is_imm;
    logic        gr_we;
    logic        mem_en;
    logic        mem_we;
    logic        src_reg_is_rd;
    br_type_t    br_type;
    logic [31:0] imm;
  } dec_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/minicpu_mc_if.sv
// Instruction and data req/ack memory ports of the minicpu core.
interface minicpu_mc_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
    input  inst_ack, inst_rdata, data_ack, data_rdata
  );

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
    output inst_ack, inst_rdata, data_ack, data_rdata
  );
endinterface

// File: rtl/minicpu_mc_decode.sv
// Combinational decoder: instruction register to control bundle and immediate.
module minicpu_mc_decode
  import minicpu_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_ADD;
    dec.br_type = BR_NONE;
    if (ir[31:15] == OP_ADD_W) begin
      dec.gr_we = 1'b1;
    end else if (ir[31:15] == OP_SUB_W) begin
      dec.alu_op = ALU_SUB;
      dec.gr_we  = 1'b1;
    end else if (ir[31:22] == OP_ADDI_W) begin
      dec.src2_is_imm = 1'b1;
      dec.gr_we       = 1'b1;
      dec.imm         = sext12(ir[21:10]);
    end else if (ir[31:25] == OP_LU12I_W) begin
      dec.alu_op      = ALU_LUI;
      dec.src2_is_imm = 1'b1;
      dec.gr_we       = 1'b1;
      dec.imm         = {ir[24:5], 12'h000};
    end else if (ir[31:22] == OP_LD_W) begin
      dec.src2_is_imm = 1'b1;
      dec.gr_we       = 1'b1;
      dec.mem_en      = 1'b1;
      dec.imm         = sext12(ir[21:10]);
    end else if (ir[31:22] == OP_ST_W) begin
      dec.src2_is_imm   = 1'b1;
      dec.mem_en        = 1'b1;
      dec.mem_we        = 1'b1;
      dec.src_reg_is_rd = 1'b1;
      dec.imm           = sext12(ir[21:10]);
    end else if (ir[31:26] == OP_BEQ || ir[31:26] == OP_BNE) begin
      // beq/bne compare rj against rd, so the second read port is steered to rd
      dec.br_type       = (ir[31:26] == OP_BEQ) ? BR_BEQ : BR_BNE;
      dec.src_reg_is_rd = 1'b1;
      dec.imm           = {{14{ir[25]}}, ir[25:10], 2'b00};
    end else if (ir[31:26] == OP_B) begin
      dec.br_type = BR_B;
      dec.imm     = {{4{ir[9]}}, ir[9:0], ir[25:10], 2'b00};
    end
  end

endmodule

// File: rtl/minicpu_regfile.sv
// 32x32 register file, two async read ports, one write port; r0 reads as zero.
module minicpu_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] rf [32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : rf[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : rf[raddr2];

endmodule

// File: rtl/minicpu_mc_top.sv
// Multi-cycle LoongArch-32 subset core, IF/ID/EX/MEM/WB over req/ack memory ports.
// Optional writeback trace outputs are built when MINICPU_TRACE_EN is defined.
module minicpu_mc_top
  import minicpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  minicpu_mc_if.master     bus,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`ifdef MINICPU_TRACE_EN
  ,
  output logic [31:0]      debug_wb_pc,
  output logic             debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  dec_t        dec;
  logic [31:0] pc, ir, next_pc;
  logic [31:0] rj_val, r2_val, ex_res, ld_data;
  logic [31:0] rf_rdata1, rf_rdata2, op2, alu_res, wb_data;
  logic [4:0]  rd, rj, rk, raddr2;
  logic        rf_we, br_taken;

  assign rd = ir[4:0];
  assign rj = ir[9:5];
  assign rk = ir[14:10];

  minicpu_mc_decode u_dec (
    .ir  (ir),
    .dec (dec)
  );

  assign raddr2 = dec.src_reg_is_rd ? rd : rk;
  assign rf_we  = (state == S_WB) && dec.gr_we && (rd != 5'd0);
  assign wb_data = dec.mem_en ? ld_data : ex_res;

  minicpu_regfile u_rf (
    .clk    (clk),
    .resetn (resetn),
    .raddr1 (rj),
    .rdata1 (rf_rdata1),
    .raddr2 (raddr2),
    .rdata2 (rf_rdata2),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (wb_data)
  );

  assign op2 = dec.src2_is_imm ? dec.imm : r2_val;

  always_comb begin
    alu_res = rj_val + op2;
    case (dec.alu_op)
      ALU_SUB: alu_res = rj_val - op2;
      ALU_LUI: alu_res = dec.imm;
      default: alu_res = rj_val + op2;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (dec.br_type)
      BR_BEQ:  br_taken = (rj_val == r2_val);
      BR_BNE:  br_taken = (rj_val != r2_val);
      BR_B:    br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  // Bus outputs decode straight from state so an async reset drops them at once
  assign bus.inst_req   = (state == S_IF);
  assign bus.inst_addr  = (state == S_IF) ? pc : 32'h0;
  assign bus.data_req   = (state == S_MEM);
  assign bus.data_we    = (state == S_MEM) && dec.mem_we;
  assign bus.data_addr  = (state == S_MEM) ? ex_res : 32'h0;
  assign bus.data_wdata = ((state == S_MEM) && dec.mem_we) ? r2_val : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      next_pc <= '0;
      rj_val  <= '0;
      r2_val  <= '0;
      ex_res  <= '0;
      ld_data <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_IF;
        S_IF: if (bus.inst_ack) begin
          ir    <= bus.inst_rdata;
          state <= S_ID;
        end
        S_ID: begin
          rj_val <= rf_rdata1;
          r2_val <= rf_rdata2;
          state  <= S_EX;
        end
        S_EX: begin
          ex_res  <= alu_res;
          next_pc <= br_taken ? pc + dec.imm : pc + 32'd4;
          state   <= dec.mem_en ? S_MEM : S_WB;
        end
        S_MEM: if (bus.data_ack) begin
          if (!dec.mem_we) ld_data <= bus.data_rdata;
          state <= S_WB;
        end
        S_WB: begin
          pc    <= next_pc;
          state <= S_IF;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_IDLE) cycle_cnt   <= cycle_cnt + CNT_ONE;
      if (state == S_WB)   instret_cnt <= instret_cnt + CNT_ONE;
    end
  end

`ifdef MINICPU_TRACE_EN
  assign debug_wb_pc       = (state == S_WB) ? pc : 32'h0;
  assign debug_wb_rf_we    = rf_we;
  assign debug_wb_rf_wnum  = (state == S_WB) ? rd : 5'd0;
  assign debug_wb_rf_wdata = (state == S_WB) ? wb_data : 32'h0;
`endif

endmodule
